// File: rtl/vote_ballot_ctrl_if.sv
// Ballot controller bus interface.
// Groups the officer and button inputs and the status and vote outputs of
// vote_ballot_ctrl.
//   master modport : drives i_* and observes o_* (booth hardware / testbench)
//   slave  modport : the controller itself
// state_dbg exposes the controller FSM state encoding for checkers:
//   0 IDLE, 1 ARMED, 2 EMIT, 3 LOCKOUT, 4 CLOSED
// Signal directions (slave view):
//   in  i_btn_1..3       raw candidate buttons (asynchronous, may bounce)
//   in  i_ballot_enable  officer pulse that arms one ballot
//   in  i_voting_over    level that closes the booth
//   out o_candidate_1..3 one-cycle vote pulse
//   out o_ready          ballot armed
//   out o_vote_done      one-cycle pulse, coincident with the vote pulse
//   out o_error          one-cycle multi-press pulse
//   out o_timeout        one-cycle ballot-voided pulse
//   out o_closed         booth closed (sticky until rst)
//   out o_ballots_cast   saturating vote count
//   out state_dbg        FSM state
// Handshake: there is no backpressure. Every o_* pulse is valid for exactly
// one clock cycle and the consumer must be ready to take it on that cycle.
interface vote_ballot_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_btn_1;
  logic             i_btn_2;
  logic             i_btn_3;
  logic             i_ballot_enable;
  logic             i_voting_over;
  logic             o_candidate_1;
  logic             o_candidate_2;
  logic             o_candidate_3;
  logic             o_ready;
  logic             o_vote_done;
  logic             o_error;
  logic             o_timeout;
  logic             o_closed;
  logic [CNT_W-1:0] o_ballots_cast;
  logic [2:0]       state_dbg;

  modport master (
    output i_btn_1, i_btn_2, i_btn_3, i_ballot_enable, i_voting_over,
    input  o_candidate_1, o_candidate_2, o_candidate_3, o_ready, o_vote_done,
           o_error, o_timeout, o_closed, o_ballots_cast, state_dbg
  );

  modport slave (
    input  i_btn_1, i_btn_2, i_btn_3, i_ballot_enable, i_voting_over,
    output o_candidate_1, o_candidate_2, o_candidate_3, o_ready, o_vote_done,
           o_error, o_timeout, o_closed, o_ballots_cast, state_dbg
  );
endinterface

// File: rtl/vote_ballot_ctrl.sv
// Ballot front-end for voting_machine.
// Synchronises and debounces three raw candidate buttons, accepts one vote
// per officer-issued ballot and emits a single-cycle o_candidate_k pulse.
// Ambiguous multi-button presses raise o_error, unused ballots time out and
// the booth locks permanently once voting closes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  vote_ballot_ctrl_if slave modport (buttons, officer controls, status)
module vote_ballot_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int CNT_W           = 16
) (
  input logic               clk,
  input logic               rst,
  vote_ballot_ctrl_if.slave bus
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXC = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    EMIT    = 3'd2,
    LOCKOUT = 3'd3,
    CLOSED  = 3'd4
  } state_t;

  // ---------------- input path ----------------
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, deb, deb_q;
  logic [DW-1:0] dcnt [3];
  logic [2:0]    events;
  logic          one_ev, multi_ev;

  assign raw = {bus.i_btn_3, bus.i_btn_2, bus.i_btn_1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int k = 0; k < 3; k++) dcnt[k] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k]) begin
          // Count saturates at the threshold; the level sets on the edge
          // the count reaches it and then holds while the button stays high.
          if (dcnt[k] != DW'(DEBOUNCE_CYCLES)) dcnt[k] <= dcnt[k] + 1'b1;
          if (dcnt[k] == DW'(DEBOUNCE_CYCLES - 1)) deb[k] <= 1'b1;
        end else begin
          dcnt[k] <= '0;
          deb[k]  <= 1'b0;
        end
      end
    end
  end

  assign events   = deb & ~deb_q;
  assign one_ev   = (events != 3'b000) && ((events & (events - 3'b001)) == 3'b000);
  assign multi_ev = (events != 3'b000) && !one_ev;

  // ---------------- ballot FSM ----------------
  state_t           state, state_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic [2:0]       cand_q, cand_n;
  logic             err_q, err_n;
  logic             to_q, to_n;
  logic [CNT_W-1:0] cast_q, cast_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tmr    <= '0;
      cand_q <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
      cast_q <= '0;
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      cand_q <= cand_n;
      err_q  <= err_n;
      to_q   <= to_n;
      cast_q <= cast_n;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    cand_n  = cand_q;
    err_n   = 1'b0;
    to_n    = 1'b0;
    cast_n  = cast_q;
    case (state)
      IDLE: begin
        if (bus.i_voting_over) begin
          state_n = CLOSED;
        end else if (bus.i_ballot_enable) begin
          state_n = ARMED;
          tmr_n   = '0;
        end
      end
      ARMED: begin
        // Closing discards the ballot silently; a valid vote beats timeout.
        if (bus.i_voting_over) begin
          state_n = CLOSED;
        end else if (one_ev) begin
          state_n = EMIT;
          cand_n  = events;
        end else if (multi_ev) begin
          err_n = 1'b1;
          // Hold the timer at its last value so a multi-press on the final
          // cycle defers the timeout by one cycle rather than wrapping.
          if (tmr != TW'(TIMEOUT_CYCLES - 1)) tmr_n = tmr + 1'b1;
        end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
          to_n    = 1'b1;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      EMIT: begin
        cast_n  = (&cast_q) ? cast_q : cast_q + 1'b1;
        tmr_n   = '0;
        state_n = bus.i_voting_over ? CLOSED : LOCKOUT;
      end
      LOCKOUT: begin
        if (bus.i_voting_over) begin
          state_n = CLOSED;
        end else if (tmr != TW'(LOCKOUT_CYCLES - 1)) begin
          tmr_n = tmr + 1'b1;
        end else if (deb == 3'b000) begin
          state_n = IDLE;
        end
      end
      CLOSED: state_n = CLOSED;
      default: state_n = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  assign bus.o_candidate_1  = (state == EMIT) && cand_q[0];
  assign bus.o_candidate_2  = (state == EMIT) && cand_q[1];
  assign bus.o_candidate_3  = (state == EMIT) && cand_q[2];
  assign bus.o_vote_done    = (state == EMIT);
  assign bus.o_ready        = (state == ARMED);
  assign bus.o_closed       = (state == CLOSED);
  assign bus.o_error        = err_q;
  assign bus.o_timeout      = to_q;
  assign bus.o_ballots_cast = cast_q;
  assign bus.state_dbg      = state;

endmodule

// File: tb/tb_vote_ballot_ctrl.sv
module tb_vote_ballot_ctrl;
  localparam int D     = 4;
  localparam int L     = 8;
  localparam int T     = 20;
  localparam int CNT_W = 16;

  localparam int ST_IDLE   = 0;
  localparam int ST_CLOSED = 4;

  logic clk;
  logic rst;

  vote_ballot_ctrl_if #(.CNT_W(CNT_W)) bus ();

  vote_ballot_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .TIMEOUT_CYCLES (T),
    .CNT_W          (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  logic [3:0] obs_q[$];
  int         obs_cyc_q[$];
  int         err_cnt = 0;
  int         to_cnt  = 0;
  int         to_cyc  = 0;
  int         c1 = 0, c2 = 0, c3 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_vote_done || bus.o_candidate_1 || bus.o_candidate_2 || bus.o_candidate_3) begin
        obs_q.push_back({bus.o_vote_done, bus.o_candidate_3, bus.o_candidate_2, bus.o_candidate_1});
        obs_cyc_q.push_back(cyc);
        if (bus.o_candidate_1) c1++;
        if (bus.o_candidate_2) c2++;
        if (bus.o_candidate_3) c3++;
      end
      if (bus.o_error) err_cnt++;
      if (bus.o_timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int         rd = 0;
  int         exp_ballots = 0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drain();
    logic [2:0] e;
    while (rd < obs_q.size()) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(obs_q[rd]), 0);
      end else begin
        e = exp_q.pop_front();
        check("vote_pulse", int'(obs_q[rd]), int'({1'b1, e}));
      end
      rd++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic [2:0] m);
    bus.i_btn_1 = m[0];
    bus.i_btn_2 = m[1];
    bus.i_btn_3 = m[2];
  endtask

  // Returns the number of the edge that samples the enable.
  task automatic arm(output int a);
    bus.i_ballot_enable = 1'b1;
    a = cyc + 1;
    tick(1);
    bus.i_ballot_enable = 1'b0;
  endtask

  task automatic do_vote(input logic [2:0] m);
    int a;
    arm(a);
    set_btn(m);
    exp_q.push_back(m);
    exp_ballots++;
    tick(10);
    set_btn(3'b000);
    tick(16);
    drain();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] btn;
    logic [2:0] cand;
    logic       err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int a, t0, e0, to0, b1, b2, b3;
    vecs[0] = '{3'b001, 3'b001, 1'b0};
    vecs[1] = '{3'b010, 3'b010, 1'b0};
    vecs[2] = '{3'b100, 3'b100, 1'b0};
    vecs[3] = '{3'b101, 3'b000, 1'b1};
    vecs[4] = '{3'b011, 3'b000, 1'b1};
    vecs[5] = '{3'b111, 3'b000, 1'b1};
    vecs[6] = '{3'b110, 3'b000, 1'b1};

    rst = 1'b1;
    set_btn(3'b000);
    bus.i_ballot_enable = 1'b0;
    bus.i_voting_over   = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_state", int'(bus.state_dbg), ST_IDLE);
    check("rst_ready", int'(bus.o_ready), 0);
    check("rst_closed", int'(bus.o_closed), 0);
    check("rst_cast", int'(bus.o_ballots_cast), 0);
    check("rst_pulses", int'({bus.o_vote_done, bus.o_error, bus.o_timeout}), 0);

    // Hold button, check exact latency: pulse after edge t0+D+2
    arm(a);
    set_btn(3'b001);
    t0 = cyc + 1;
    exp_q.push_back(3'b001);
    exp_ballots++;
    tick(10);
    set_btn(3'b000);
    check("latency_btn1", obs_cyc_q.size() > rd ? obs_cyc_q[rd] : -1, t0 + D + 2);
    tick(16);
    drain();
    check("cast_after_first", int'(bus.o_ballots_cast), exp_ballots);

    // Bouncing button: 1,0,1,0 then settles high
    arm(a);
    set_btn(3'b010); tick(1);
    set_btn(3'b000); tick(1);
    set_btn(3'b010); tick(1);
    set_btn(3'b000); tick(1);
    set_btn(3'b010);
    t0 = cyc + 1;
    exp_q.push_back(3'b010);
    exp_ballots++;
    tick(12);
    set_btn(3'b000);
    check("bounce_count", obs_q.size() - rd, 1);
    check("latency_bounce", obs_cyc_q.size() > rd ? obs_cyc_q[rd] : -1, t0 + D + 2);
    tick(16);
    drain();

    // Table: single presses vote, multi presses error and later time out
    for (int i = 0; i < 7; i++) begin
      e0  = err_cnt;
      to0 = to_cnt;
      arm(a);
      set_btn(vecs[i].btn);
      if (!vecs[i].err) begin
        exp_q.push_back(vecs[i].cand);
        exp_ballots++;
      end
      tick(12);
      check($sformatf("vec%0d_ready", i), int'(bus.o_ready), int'(vecs[i].err));
      set_btn(3'b000);
      tick(30);
      drain();
      check($sformatf("vec%0d_error", i), err_cnt - e0, int'(vecs[i].err));
      check($sformatf("vec%0d_timeout", i), to_cnt - to0, int'(vecs[i].err));
      check($sformatf("vec%0d_state", i), int'(bus.state_dbg), ST_IDLE);
    end
    check("cast_after_table", int'(bus.o_ballots_cast), exp_ballots);

    // Error then valid re-press within the same ballot
    e0 = err_cnt;
    arm(a);
    set_btn(3'b101);
    tick(8);
    check("err_ready_held", int'(bus.o_ready), 1);
    set_btn(3'b000);
    tick(2);
    set_btn(3'b100);
    exp_q.push_back(3'b100);
    exp_ballots++;
    tick(10);
    set_btn(3'b000);
    tick(16);
    drain();
    check("err_then_vote_err", err_cnt - e0, 1);

    // Timeout with no press, then presses in IDLE are ignored
    to0 = to_cnt;
    arm(a);
    tick(25);
    check("timeout_count", to_cnt - to0, 1);
    check("timeout_cycle", to_cyc, a + T);
    check("timeout_state", int'(bus.state_dbg), ST_IDLE);
    set_btn(3'b001);
    tick(10);
    set_btn(3'b000);
    tick(5);
    drain();
    check("idle_press_cast", int'(bus.o_ballots_cast), exp_ballots);

    // Lockout: enable ignored, second press ignored
    arm(a);
    set_btn(3'b001);
    exp_q.push_back(3'b001);
    exp_ballots++;
    tick(10);
    bus.i_ballot_enable = 1'b1;
    tick(1);
    bus.i_ballot_enable = 1'b0;
    tick(1);
    check("lockout_enable_ignored", int'(bus.o_ready), 0);
    set_btn(3'b010);
    tick(6);
    set_btn(3'b000);
    tick(20);
    drain();
    check("lockout_state", int'(bus.state_dbg), ST_IDLE);
    check("lockout_not_queued", int'(bus.o_ready), 0);
    check("lockout_cast", int'(bus.o_ballots_cast), exp_ballots);

    // Three votes then close the booth
    b1 = c1; b2 = c2; b3 = c3;
    do_vote(3'b001);
    do_vote(3'b010);
    do_vote(3'b001);
    bus.i_voting_over = 1'b1;
    tick(2);
    check("closed_flag", int'(bus.o_closed), 1);
    check("closed_state", int'(bus.state_dbg), ST_CLOSED);
    arm(a);
    set_btn(3'b100);
    tick(10);
    set_btn(3'b000);
    tick(5);
    drain();
    check("closed_ready", int'(bus.o_ready), 0);
    check("closed_cast", int'(bus.o_ballots_cast), exp_ballots);
    check("downstream_c1", c1 - b1, 2);
    check("downstream_c2", c2 - b2, 1);
    check("downstream_c3", c3 - b3, 0);

    // Reset clears everything
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    bus.i_voting_over = 1'b0;
    tick(1);
    check("rst2_closed", int'(bus.o_closed), 0);
    check("rst2_cast", int'(bus.o_ballots_cast), 0);
    check("rst2_state", int'(bus.state_dbg), ST_IDLE);

    drain();
    check("missing_pulses", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
